// File: rtl/universal_register.sv
// WIDTH-bit register with clear, enable, load, shift, rotate and up/down count.
// Single-cycle update, async active-high reset; outputs decode q only (tc also sees controls).
module universal_register #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_ser_lsb,
  input  logic             i_ser_msb,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qbar,
  output logic             o_so_msb,
  output logic             o_so_lsb,
  output logic             o_tc
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_UP   = 3'b110,
    M_DN   = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_all_ones;
  logic             w_zero;
  mode_e            w_mode;

  assign w_mode = mode_e'(i_mode);

  always_comb begin
    w_next = r_q;
    if (i_clr) begin
      w_next = '0;
    end else if (i_en) begin
      case (w_mode)
        M_HOLD:  w_next = r_q;
        M_LOAD:  w_next = i_d;
        M_SHL:   w_next = {r_q[WIDTH-2:0], i_ser_lsb};
        M_SHR:   w_next = {i_ser_msb, r_q[WIDTH-1:1]};
        M_ROL:   w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        M_ROR:   w_next = {r_q[0], r_q[WIDTH-1:1]};
        M_UP:    w_next = r_q + 1'b1;
        M_DN:    w_next = r_q - 1'b1;
        default: w_next = r_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_q <= RST_VAL;
    else       r_q <= w_next;
  end

  assign w_all_ones = &r_q;
  assign w_zero     = ~|r_q;

  assign o_q      = r_q;
  assign o_qbar   = ~r_q;
  assign o_so_msb = r_q[WIDTH-1];
  assign o_so_lsb = r_q[0];
  // Flags that the coming edge wraps the counter.
  assign o_tc     = i_en & ~i_clr &
                    (((w_mode == M_UP) & w_all_ones) | ((w_mode == M_DN) & w_zero));

endmodule
